instruction_memory_loader: RTL and testbench
============================================

Name: instruction_memory_loader

Overview:
- Writer side of the instruction memory: receives a program as a serial byte stream (UART RX byte strobes from the debug unit), assembles 32-bit instruction words, and issues single-cycle write strobes with byte addresses into the instruction memory write port.
- Loading stops on a HALT word, or flags an error when memory capacity is exhausted first.
- Sits between the debug/UART receiver and the instruction memory; the CPU is held off while o_busy is high.

Parameters:
- NB_DATA, 32, instruction word width (multiple of NB_BYTE).
- NB_BYTE, 8, received byte width.
- LOG2_N_INSMEM_ADDR, 12, width of the byte address driven to the memory. Word capacity is N_WORDS = 2^(LOG2_N_INSMEM_ADDR-2) = 1024.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  begin a new load; sampled in IDLE, DONE and ERROR.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_wr_enable  out  1  one-cycle memory write strobe.
- o_wr_addr  out  LOG2_N_INSMEM_ADDR  byte address of the write; bits [1:0] are always 0.
- o_wr_data  out  NB_DATA  word to write.
- o_busy  out  1  high in LOAD.
- o_done  out  1  load ended on HALT_WORD; sticky.
- o_error  out  1  capacity exhausted without HALT_WORD; sticky.
- o_word_count  out  LOG2_N_INSMEM_ADDR-1  number of words written in the current or last load.

Behaviour:
- Reset (i_reset=1, synchronous) has priority over every other input:
  - state returns to IDLE;
  - all outputs go to 0;
  - the byte counter, assembly register and word index are cleared.
- Reset mid-load discards any partial word and performs no write in the following cycle.
- States:
  - IDLE: i_start=1 -> LOAD; clears counters, o_done, o_error and o_word_count.
  - LOAD: o_busy=1. Each cycle with i_rx_valid=1 shifts the byte in: asm <= {asm[NB_DATA-NB_BYTE-1:0], i_rx_data}. The first byte received becomes the MSB (big-endian). byte_cnt increments modulo 4.
  - DONE: o_done=1. i_start=1 -> LOAD with a fresh load; counters and flags cleared as in IDLE.
  - ERROR: o_error=1. i_start=1 -> LOAD with a fresh load; counters and flags cleared as in IDLE.
- Word write, on the edge that accepts the 4th byte of a word:
  - o_wr_data <= the completed word;
  - o_wr_addr <= word_idx << 2;
  - o_wr_enable <= 1 for exactly one cycle;
  - word_idx and o_word_count increment;
  - byte_cnt returns to 0.
- Write latency is one cycle from the 4th byte strobe. o_wr_addr and o_wr_data hold their last values after the strobe.
- Termination, decided on the same edge as the write:
  - completed word == HALT_WORD: the HALT word is written, then state -> DONE (o_busy falls and o_done rises in the strobe cycle).
  - otherwise, if word_idx was N_WORDS-1: that word is written, then state -> ERROR.
  - HALT_WORD takes precedence when it lands in the last slot (-> DONE).
- Back-to-back bytes on consecutive cycles are accepted with no gaps. A byte arriving in the write-strobe cycle of the previous word is the first byte of the next word; no byte is ever dropped in LOAD.
- i_rx_valid is ignored in IDLE, DONE and ERROR.
- i_start is ignored in LOAD.
- A partial word (1–3 bytes) left when the load ends is never written.
- Addresses advance strictly 0, 4, 8, … with no wrap. Overflow ends in ERROR, never at address 0.

Test Plan:
- Reset, then i_start, then bytes 8C,01,00,04 -> one-cycle o_wr_enable with o_wr_addr=0, o_wr_data=8C010004, o_word_count=1, o_busy=1.
- 12 bytes on consecutive cycles forming 00000020, 20420001, FFFFFFFF -> writes at addresses 0, 4, 8 with exactly those data values; o_done=1 and o_busy=0 after the third strobe; further bytes cause no writes.
- Stream 1024 non-HALT words -> 1024 strobes at addresses 0..0xFFC; o_error=1 after the last one, no write at address 0x1000 or 0; o_word_count=1024 (11-bit field).
- Same as above, but word 1024 = FFFFFFFF -> o_done=1 and o_error=0.
- Two bytes sent, i_reset pulsed, then i_start and bytes 11,22,33,44 -> single write of 11223344 at address 0; the stale bytes do not appear.
- In DONE, send bytes then assert i_start -> no writes before the restart; after it, o_done clears and addresses restart at 0.

Source files
------------

// File: rtl/instruction_memory_loader.sv
// Assembles a big-endian serial byte stream into instruction words and writes them
// to the instruction memory, stopping on the HALT word or when capacity runs out.
module instruction_memory_loader #(
  parameter int                 NB_DATA            = 32,
  parameter int                 NB_BYTE            = 8,
  parameter int                 LOG2_N_INSMEM_ADDR = 12,
  parameter logic [NB_DATA-1:0] HALT_WORD          = 32'hFFFFFFFF
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_wr_enable,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]            o_wr_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [LOG2_N_INSMEM_ADDR-2:0] o_word_count
);

  localparam int N_WORDS        = 2 ** (LOG2_N_INSMEM_ADDR - 2);
  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int IDX_W          = LOG2_N_INSMEM_ADDR - 2;
  localparam int WC_W           = LOG2_N_INSMEM_ADDR - 1;
  localparam int ASM_W          = NB_DATA - NB_BYTE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]                asm_q, asm_d;
  logic [WC_W-1:0]                 word_count_q, word_count_d;
  logic                            wr_enable_q, wr_enable_d;
  logic [LOG2_N_INSMEM_ADDR-1:0]   wr_addr_q, wr_addr_d;
  logic [NB_DATA-1:0]              wr_data_q, wr_data_d;
  logic [NB_DATA-1:0]              word;

  // Only the first three bytes need storing; the word completes with the live byte.
  assign word = {asm_q, i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_count_q <= '0;
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    wr_enable_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d      = S_LOAD;
          byte_cnt_d   = '0;
          asm_d        = '0;
          word_count_d = '0;
        end
      end
      S_LOAD: begin
        if (i_rx_valid) begin
          asm_d = word[ASM_W-1:0];
          if (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
            wr_enable_d  = 1'b1;
            wr_data_d    = word;
            wr_addr_d    = {word_count_q[IDX_W-1:0], 2'b00};
            word_count_d = word_count_q + 1'b1;
            byte_cnt_d   = '0;
            // HALT wins even when it lands in the final slot.
            if (word == HALT_WORD) begin
              state_d = S_DONE;
            end else if (word_count_q == WC_W'(N_WORDS - 1)) begin
              state_d = S_ERROR;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_wr_enable  = wr_enable_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_word_count = word_count_q;
  assign o_busy       = (state_q == S_LOAD);
  assign o_done       = (state_q == S_DONE);
  assign o_error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: every write strobe is logged and
// compared against hand-computed addresses and data.
module tb_instruction_memory_loader;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_wr_enable;
  logic [11:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [10:0] o_word_count;

  int checks = 0;
  int errors = 0;

  logic [11:0] addr_log[$];
  logic [31:0] data_log[$];

  instruction_memory_loader dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_wr_enable  (o_wr_enable),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A strobe held for more than one cycle shows up as extra log entries.
  always @(negedge clk) begin
    if (o_wr_enable) begin
      addr_log.push_back(o_wr_addr);
      data_log.push_back(o_wr_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
  endtask

  task automatic startLoad();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic resetPulse();
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
  endtask

  task automatic clearLog();
    addr_log.delete();
    data_log.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int bad;

    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    tick(2);
    checkOutput("rst_wr_enable", 32'(o_wr_enable), 32'd0);
    checkOutput("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    checkOutput("rst_wr_data", o_wr_data, 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_error", 32'(o_error), 32'd0);
    checkOutput("rst_word_count", 32'(o_word_count), 32'd0);
    i_reset = 1'b0;

    $display("[TB] single word");
    applyStimulus(8'h55);
    tick(1);
    checkOutput("idle_ignores_rx", 32'(o_busy), 32'd0);
    startLoad();
    checkOutput("load_busy", 32'(o_busy), 32'd1);
    sendWord(32'h8C010004);
    checkOutput("w1_enable", 32'(o_wr_enable), 32'd1);
    checkOutput("w1_addr", 32'(o_wr_addr), 32'h000);
    checkOutput("w1_data", o_wr_data, 32'h8C010004);
    checkOutput("w1_count", 32'(o_word_count), 32'd1);
    checkOutput("w1_busy", 32'(o_busy), 32'd1);
    tick(1);
    checkOutput("w1_strobe_one_cycle", 32'(o_wr_enable), 32'd0);
    checkOutput("w1_data_hold", o_wr_data, 32'h8C010004);

    $display("[TB] three words ending in HALT");
    resetPulse();
    startLoad();
    clearLog();
    sendWord(32'h00000020);
    sendWord(32'h20420001);
    sendWord(32'hFFFFFFFF);
    checkOutput("halt_enable", 32'(o_wr_enable), 32'd1);
    checkOutput("halt_done", 32'(o_done), 32'd1);
    checkOutput("halt_busy", 32'(o_busy), 32'd0);
    checkOutput("halt_count", 32'(o_word_count), 32'd3);
    tick(1);
    checkOutput("halt_log_size", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3) begin
      checkOutput("halt_addr0", 32'(addr_log[0]), 32'h000);
      checkOutput("halt_data0", data_log[0], 32'h00000020);
      checkOutput("halt_addr1", 32'(addr_log[1]), 32'h004);
      checkOutput("halt_data1", data_log[1], 32'h20420001);
      checkOutput("halt_addr2", 32'(addr_log[2]), 32'h008);
      checkOutput("halt_data2", data_log[2], 32'hFFFFFFFF);
    end

    $display("[TB] bytes in DONE then restart");
    sendWord(32'hDEADBEEF);
    sendWord(32'h01020304);
    tick(2);
    checkOutput("done_no_writes", 32'(addr_log.size()), 32'd3);
    checkOutput("done_sticky", 32'(o_done), 32'd1);
    startLoad();
    checkOutput("restart_done_clr", 32'(o_done), 32'd0);
    checkOutput("restart_busy", 32'(o_busy), 32'd1);
    checkOutput("restart_count_clr", 32'(o_word_count), 32'd0);
    sendWord(32'h12345678);
    checkOutput("restart_addr", 32'(o_wr_addr), 32'h000);
    checkOutput("restart_data", o_wr_data, 32'h12345678);
    sendWord(32'hFFFFFFFF);

    $display("[TB] overflow without HALT");
    startLoad();
    clearLog();
    for (int k = 0; k < 1024; k++) sendWord(32'(k));
    checkOutput("ovf_enable", 32'(o_wr_enable), 32'd1);
    checkOutput("ovf_last_addr", 32'(o_wr_addr), 32'hFFC);
    checkOutput("ovf_error", 32'(o_error), 32'd1);
    checkOutput("ovf_done", 32'(o_done), 32'd0);
    checkOutput("ovf_busy", 32'(o_busy), 32'd0);
    checkOutput("ovf_count", 32'(o_word_count), 32'd1024);
    sendWord(32'h0000AAAA);
    tick(2);
    checkOutput("ovf_log_size", 32'(addr_log.size()), 32'd1024);
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++) begin
      if (addr_log[k] !== 12'(k * 4) || data_log[k] !== 32'(k)) bad++;
    end
    checkOutput("ovf_sequence_bad", 32'(bad), 32'd0);

    $display("[TB] HALT in the last slot");
    startLoad();
    checkOutput("last_error_clr", 32'(o_error), 32'd0);
    clearLog();
    for (int k = 0; k < 1023; k++) sendWord(32'(k) + 32'h100);
    sendWord(32'hFFFFFFFF);
    checkOutput("last_addr", 32'(o_wr_addr), 32'hFFC);
    checkOutput("last_data", o_wr_data, 32'hFFFFFFFF);
    checkOutput("last_done", 32'(o_done), 32'd1);
    checkOutput("last_error", 32'(o_error), 32'd0);
    checkOutput("last_count", 32'(o_word_count), 32'd1024);
    tick(1);
    checkOutput("last_log_size", 32'(addr_log.size()), 32'd1024);

    $display("[TB] reset mid-load");
    startLoad();
    clearLog();
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    resetPulse();
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_enable", 32'(o_wr_enable), 32'd0);
    tick(2);
    startLoad();
    sendWord(32'h11223344);
    checkOutput("midrst_data", o_wr_data, 32'h11223344);
    checkOutput("midrst_addr", 32'(o_wr_addr), 32'h000);
    checkOutput("midrst_count", 32'(o_word_count), 32'd1);
    applyStimulus(8'h99);
    tick(2);
    checkOutput("midrst_log_size", 32'(addr_log.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
